// File: rtl/fill_request_issuer.sv
// fill_request_issuer: pulls miss tags from the fill list in order, looks up
// each tag's line address in a local table written at miss allocation, and
// issues one memory read per tag. The last beat of each fill produces a
// one-cycle delete back to the fill list, retiring that tag.
// Optional feature macro: FILL_REQ_ERR_CHECK_EN (per-tag protocol checking
// driving the sticky err output; err is tied 0 when undefined).
module fill_request_issuer #(
    parameter int TAG_BITS  = 3,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_valid,
    input  logic [TAG_BITS-1:0]  alloc_tag,
    input  logic [ADDR_BITS-1:0] alloc_addr,
    output logic                 fl_read,
    input  logic                 fl_valid,
    input  logic [TAG_BITS-1:0]  fl_tag,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [TAG_BITS-1:0]  mem_req_tag,
    input  logic                 mem_resp_valid,
    input  logic [TAG_BITS-1:0]  mem_resp_tag,
    input  logic                 mem_resp_last,
    output logic                 fl_del,
    output logic [TAG_BITS-1:0]  fl_del_tag,
    output logic [TAG_BITS:0]    outstanding,
    output logic                 err
);

    localparam int DEPTH = 1 << TAG_BITS;
    localparam logic [TAG_BITS:0] MAX_OUT = DEPTH[TAG_BITS:0];
    localparam logic [TAG_BITS:0] ONE     = {{TAG_BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_TAG = 2'd1,
        S_REQ      = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic                                req_valid_q, req_valid_d;
    logic [ADDR_BITS-1:0]                req_addr_q, req_addr_d;
    logic [TAG_BITS-1:0]                 req_tag_q, req_tag_d;
    logic                                del_q, del_d;
    logic [TAG_BITS-1:0]                 del_tag_q, del_tag_d;
    logic [TAG_BITS:0]                   out_q, out_d;
    logic [DEPTH-1:0][ADDR_BITS-1:0]     addr_tab_q, addr_tab_d;
    logic                                fl_read_c;
    logic                                issue;
    logic                                retire;

    assign issue  = req_valid_q && mem_req_ready;
    assign retire = mem_resp_valid && mem_resp_last;

    // Address table update: written at miss allocation, indexed by tag
    always_comb begin
        addr_tab_d = addr_tab_q;
        if (alloc_valid) begin
            addr_tab_d[alloc_tag] = alloc_addr;
        end
    end

    // Address table storage (contents are don't-care until allocated)
    always_ff @(posedge clk) begin
        addr_tab_q <= addr_tab_d;
    end

    // Issue FSM: read a tag, latch the request, hold until accepted
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_tag_d   = req_tag_q;
        fl_read_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Never combine a read with a delete in the same cycle
                if (!del_q && (out_q < MAX_OUT)) begin
                    fl_read_c = 1'b1;
                    state_d   = S_WAIT_TAG;
                end
            end
            S_WAIT_TAG: begin
                if (fl_valid) begin
                    req_tag_d   = fl_tag;
                    req_addr_d  = addr_tab_q[fl_tag];
                    req_valid_d = 1'b1;
                    state_d     = S_REQ;
                end else begin
                    // List was empty; go back and retry
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (issue) begin
                    req_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Retire path and outstanding count
    always_comb begin
        del_d     = retire;
        del_tag_d = retire ? mem_resp_tag : del_tag_q;
        out_d     = out_q;
        case ({issue, retire})
            2'b10:   out_d = out_q + ONE;
            2'b01:   out_d = out_q - ONE;
            default: out_d = out_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_tag_q   <= '0;
            del_q       <= 1'b0;
            del_tag_q   <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_tag_q   <= req_tag_d;
            del_q       <= del_d;
            del_tag_q   <= del_tag_d;
            out_q       <= out_d;
        end
    end

    // Read strobe is held low while reset is asserted
    assign fl_read       = fl_read_c && reset;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_tag   = req_tag_q;
    assign fl_del        = del_q;
    assign fl_del_tag    = del_tag_q;
    assign outstanding   = out_q;

`ifdef FILL_REQ_ERR_CHECK_EN
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             err_q, err_d;

    // Track issued tags; flag retire of an idle tag or reissue of a busy one
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (retire) begin
            if (!busy_q[mem_resp_tag]) begin
                err_d = 1'b1;
            end
            busy_d[mem_resp_tag] = 1'b0;
        end
        if (issue) begin
            if (busy_q[req_tag_q]) begin
                err_d = 1'b1;
            end
            busy_d[req_tag_q] = 1'b1;
        end
    end

    // Checker state, err sticky until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fill_request_issuer.sv
// Directed bench for fill_request_issuer: request latency, ready back-pressure,
// multi-beat retire, full-occupancy stall, empty-list retry, back-to-back and
// concurrent retire, err behaviour and asynchronous reset during a request.
module tb_fill_request_issuer;

    localparam int TB = 3;
    localparam int AB = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_valid;
    logic [TB-1:0] alloc_tag;
    logic [AB-1:0] alloc_addr;
    logic          fl_read;
    logic          fl_valid;
    logic [TB-1:0] fl_tag;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AB-1:0] mem_req_addr;
    logic [TB-1:0] mem_req_tag;
    logic          mem_resp_valid;
    logic [TB-1:0] mem_resp_tag;
    logic          mem_resp_last;
    logic          fl_del;
    logic [TB-1:0] fl_del_tag;
    logic [TB:0]   outstanding;
    logic          err;

    int checks = 0;
    int errors = 0;

    fill_request_issuer #(.TAG_BITS(TB), .ADDR_BITS(AB)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_addr(alloc_addr),
        .fl_read(fl_read), .fl_valid(fl_valid), .fl_tag(fl_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
        .mem_resp_last(mem_resp_last),
        .fl_del(fl_del), .fl_del_tag(fl_del_tag),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AB-1:0] addr_of(input int t);
        return 32'h2000 + 32'(t) * 32'h40;
    endfunction

    // Wait for a read strobe, return tag on the next cycle, accept the request
    task automatic issue_one(input int t, input int exp_out, input logic rv, input int rtag);
        int n = 0;
        while (!fl_read && n < 20) begin
            tick;
            n++;
        end
        chk("fl_read_wait", 64'(fl_read), 64'd1);
        tick;
        fl_valid = 1'b1;
        fl_tag   = TB'(t);
        tick;
        fl_valid = 1'b0;
        chk("req_valid", 64'(mem_req_valid), 64'd1);
        chk("req_addr", 64'(mem_req_addr), 64'(addr_of(t)));
        chk("req_tag", 64'(mem_req_tag), 64'(t));
        mem_req_ready  = 1'b1;
        mem_resp_valid = rv;
        mem_resp_last  = rv;
        mem_resp_tag   = TB'(rtag);
        tick;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_last  = 1'b0;
        chk("req_drop", 64'(mem_req_valid), 64'd0);
        chk("out_after_issue", 64'(outstanding), 64'(exp_out));
    endtask

    initial begin
        reset = 1'b0;
        alloc_valid = 1'b0; alloc_tag = '0; alloc_addr = '0;
        fl_valid = 1'b0; fl_tag = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_last = 1'b0;
        #3;
        chk("rst_fl_read", 64'(fl_read), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(mem_req_addr), 64'd0);
        chk("rst_req_tag", 64'(mem_req_tag), 64'd0);
        chk("rst_fl_del", 64'(fl_del), 64'd0);
        chk("rst_del_tag", 64'(fl_del_tag), 64'd0);
        chk("rst_out", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("idle_read", 64'(fl_read), 64'd1);
        tick;
        chk("wait_no_read", 64'(fl_read), 64'd0);
        // Empty list: back to IDLE, retry, no request
        tick;
        chk("retry_read", 64'(fl_read), 64'd1);
        chk("retry_no_req", 64'(mem_req_valid), 64'd0);
        alloc_valid = 1'b1; alloc_tag = 3'd2; alloc_addr = 32'h1000;
        tick;
        alloc_valid = 1'b0;
        tick;
        chk("read_T", 64'(fl_read), 64'd1);
        tick;
        fl_valid = 1'b1; fl_tag = 3'd2;
        chk("no_req_T1", 64'(mem_req_valid), 64'd0);
        tick;
        fl_valid = 1'b0;
        chk("no_read_in_req", 64'(fl_read), 64'd0);
        // Back-pressure: five cycles of ready low, all outputs stable
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(mem_req_valid), 64'd1);
            chk("bp_addr", 64'(mem_req_addr), 64'h1000);
            chk("bp_tag", 64'(mem_req_tag), 64'd2);
            chk("bp_out", 64'(outstanding), 64'd0);
            tick;
        end
        mem_req_ready = 1'b1;
        chk("acc_valid", 64'(mem_req_valid), 64'd1);
        tick;
        mem_req_ready = 1'b0;
        chk("acc_drop", 64'(mem_req_valid), 64'd0);
        chk("acc_out", 64'(outstanding), 64'd1);
        chk("acc_read", 64'(fl_read), 64'd1);
        // Four-beat fill, last on the fourth
        for (int b = 0; b < 4; b++) begin
            mem_resp_valid = 1'b1; mem_resp_tag = 3'd2; mem_resp_last = (b == 3);
            tick;
            if (b < 3) chk("beat_no_del", 64'(fl_del), 64'd0);
        end
        mem_resp_valid = 1'b0; mem_resp_last = 1'b0;
        chk("del_1", 64'(fl_del), 64'd1);
        chk("del_tag2", 64'(fl_del_tag), 64'd2);
        chk("del_out0", 64'(outstanding), 64'd0);
        chk("del_no_read", 64'(fl_read), 64'd0);
        tick;
        chk("del_once", 64'(fl_del), 64'd0);
        // Fill all eight tags
        for (int t = 0; t < 8; t++) begin
            alloc_valid = 1'b1; alloc_tag = TB'(t); alloc_addr = addr_of(t);
            tick;
        end
        alloc_valid = 1'b0;
        for (int t = 0; t < 8; t++) issue_one(t, t + 1, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("full_no_read", 64'(fl_read), 64'd0);
        end
        chk("full_out", 64'(outstanding), 64'd8);
        mem_resp_valid = 1'b1; mem_resp_last = 1'b1; mem_resp_tag = 3'd5;
        tick;
        mem_resp_valid = 1'b0; mem_resp_last = 1'b0;
        chk("ret5_del", 64'(fl_del), 64'd1);
        chk("ret5_tag", 64'(fl_del_tag), 64'd5);
        chk("ret5_out", 64'(outstanding), 64'd7);
        chk("ret5_no_read", 64'(fl_read), 64'd0);
        tick;
        chk("resume_read", 64'(fl_read), 64'd1);
        chk("resume_no_del", 64'(fl_del), 64'd0);
        // Back-to-back last beats
        mem_resp_valid = 1'b1; mem_resp_last = 1'b1; mem_resp_tag = 3'd0;
        tick;
        mem_resp_tag = 3'd1;
        chk("b2b_del0", 64'(fl_del), 64'd1);
        chk("b2b_tag0", 64'(fl_del_tag), 64'd0);
        tick;
        mem_resp_valid = 1'b0; mem_resp_last = 1'b0;
        chk("b2b_del1", 64'(fl_del), 64'd1);
        chk("b2b_tag1", 64'(fl_del_tag), 64'd1);
        chk("b2b_out", 64'(outstanding), 64'd5);
        tick;
        chk("b2b_end", 64'(fl_del), 64'd0);
        // Reissue tag 5 with a retire of tag 6 in the handshake cycle
        issue_one(5, 5, 1'b1, 6);
        chk("conc_del", 64'(fl_del), 64'd1);
        chk("conc_tag", 64'(fl_del_tag), 64'd6);
        // Last beat for a tag with nothing outstanding (tag 1 already retired)
        mem_resp_valid = 1'b1; mem_resp_last = 1'b1; mem_resp_tag = 3'd1;
        tick;
        mem_resp_valid = 1'b0; mem_resp_last = 1'b0;
        tick;
        chk("bad_out", 64'(outstanding), 64'd4);
`ifdef FILL_REQ_ERR_CHECK_EN
        chk("err_set", 64'(err), 64'd1);
        tick;
        chk("err_sticky", 64'(err), 64'd1);
`else
        chk("err_tied0", 64'(err), 64'd0);
        tick;
        chk("err_still0", 64'(err), 64'd0);
`endif
        // Asynchronous reset while a request is pending
        begin
            int n = 0;
            while (!fl_read && n < 20) begin
                tick;
                n++;
            end
        end
        chk("pre_rst_read", 64'(fl_read), 64'd1);
        tick;
        fl_valid = 1'b1; fl_tag = 3'd3;
        tick;
        fl_valid = 1'b0;
        chk("pre_rst_req", 64'(mem_req_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_req_drop", 64'(mem_req_valid), 64'd0);
        chk("async_out", 64'(outstanding), 64'd0);
        chk("async_err", 64'(err), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
